uart_tx_queue: RTL and testbench

Byte-queue front end for the transmit side of `Uart8`. It accepts bytes from a host-side write port into a small synchronous FIFO and drives `Uart8`'s `txStart`/`txIn` handshake itself, one frame at a time, replacing hand-sequenced `txStart` pulses. It sits between system logic and the `Uart8` tx interface. The `Uart8` rx side and the serial line are untouched.

---
 rtl/uart_pkg.sv | 13 +
 rtl/byte_fifo.sv | 67 ++++++
 rtl/uart_tx_queue.sv | 90 +++++++++
 tb/tb_uart_tx_queue.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the Uart8 transmit queue: FSM encoding and default sizing.
package uart_pkg;

  localparam int DEFAULT_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    COMPLETE  = 2'd3
  } txState_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with registered full/empty/count and a registered read on pop.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wrEn,
  input  logic [7:0]        wrData,
  input  logic              rdEn,
  output logic [7:0]        rdData,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W-1:0] rdPtr;
  logic              doWr;
  logic              doRd;
  logic [ADDR_W:0]   countNext;

  // full is the registered flag, so a write on a full cycle is rejected even if a pop happens too
  assign doWr = wrEn && !full;
  assign doRd = rdEn && !empty;

  always_comb begin
    countNext = count;
    if (doWr && !doRd) begin
      countNext = count + (ADDR_W+1)'(1);
    end else if (!doWr && doRd) begin
      countNext = count - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (doWr) begin
      mem[wrPtr] <= wrData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      rdData <= 8'h00;
    end else begin
      if (doWr) begin
        wrPtr <= wrPtr + ADDR_W'(1);
      end
      if (doRd) begin
        rdPtr  <= rdPtr + ADDR_W'(1);
        rdData <= mem[rdPtr];
      end
      count <= countNext;
      full  <= (countNext == (ADDR_W+1)'(DEPTH));
      empty <= (countNext == '0);
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue in front of the Uart8 transmitter; sequences txStart/txIn one frame at a time.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            wrEn,
  input  logic [7:0]      wrData,
  output logic            full,
  output logic            empty,
  output logic [ADDR_W:0] count,
  output logic            overflow,
  output logic            sent,
  output logic            txEn,
  output logic            txStart,
  output logic [7:0]      txIn,
  input  logic            txBusy,
  input  logic            txDone
);

  txState_t state;
  txState_t stateNext;
  logic     pop;

  // The FIFO read register is txIn itself, so it only changes on the IDLE->START pop
  byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) fifo (
    .clk    (clk),
    .reset  (reset),
    .wrEn   (wrEn),
    .wrData (wrData),
    .rdEn   (pop),
    .rdData (txIn),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  always_comb begin
    stateNext = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        // !txBusy also holds off a new start while Uart8 finishes a frame cut short by reset
        if (enable && !empty && !txBusy) begin
          stateNext = START;
          pop       = 1'b1;
        end
      end
      START: begin
        if (txBusy) begin
          stateNext = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (txDone || !txBusy) begin
          stateNext = COMPLETE;
        end
      end
      COMPLETE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      txEn     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= stateNext;
      txEn     <= enable;
      overflow <= wrEn && full;
    end
  end

  assign txStart = (state == START);
  assign sent    = (state == COMPLETE);

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue against a behavioural Uart8 transmitter with a byte scoreboard.
module tb_uart_tx_queue;

  localparam int DEPTH    = 4;
  localparam int ADDR_W   = $clog2(DEPTH);
  localparam int BAUD_DIV = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              wrEn = 1'b0;
  logic [7:0]        wrData = 8'h00;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              sent;
  logic              txEn;
  logic              txStart;
  logic [7:0]        txIn;

  // behavioural Uart8 tx: accepts a start on a baud tick, busy for 10 ticks, txDone on the last
  logic              uBusy = 1'b0;
  logic              uDone = 1'b0;
  logic [7:0]        uShift = 8'h00;
  int                tickCnt = 0;
  int                bitCnt = 0;

  int                nTests = 0;
  int                nFail = 0;
  int                sentCnt = 0;
  int                ovfCnt = 0;
  int                rxCnt = 0;
  bit                ignoreFrame = 1'b0;
  bit                txInBad = 1'b0;
  bit                prevStart = 1'b0;
  logic [7:0]        expQ[$];

  always #5 clk = ~clk;

  uart_tx_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .wrEn     (wrEn),
    .wrData   (wrData),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .sent     (sent),
    .txEn     (txEn),
    .txStart  (txStart),
    .txIn     (txIn),
    .txBusy   (uBusy),
    .txDone   (uDone)
  );

  always @(posedge clk) begin
    uDone   <= 1'b0;
    tickCnt <= (tickCnt == BAUD_DIV-1) ? 0 : tickCnt + 1;
    if (tickCnt == 0) begin
      if (!uBusy) begin
        if (txStart && txEn) begin
          uBusy  <= 1'b1;
          uShift <= txIn;
          bitCnt <= 0;
        end
      end else if (bitCnt == 9) begin
        uBusy <= 1'b0;
        uDone <= 1'b1;
      end else begin
        bitCnt <= bitCnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [7:0] b, input bit accept);
    wrEn   = 1'b1;
    wrData = b;
    if (accept) expQ.push_back(b);
    tick();
    wrEn = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    while ((expQ.size() != 0 || uBusy || txStart || !empty) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) chk(tag, 32'(expQ.size()), 0);
    repeat (4) tick();
  endtask

  // waits for WAIT_DONE: Uart8 busy and txStart already released
  task automatic waitBusy(input string tag);
    int n = 0;
    while (!(uBusy && !txStart) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) chk(tag, 32'(uBusy), 1);
  endtask

  task automatic checkReset(input string p);
    chk({p, "Empty"},    32'(empty),    1);
    chk({p, "Full"},     32'(full),     0);
    chk({p, "Count"},    32'(count),    0);
    chk({p, "Overflow"}, 32'(overflow), 0);
    chk({p, "Sent"},     32'(sent),     0);
    chk({p, "TxEn"},     32'(txEn),     0);
    chk({p, "TxStart"},  32'(txStart),  0);
    chk({p, "TxIn"},     32'(txIn),     0);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (sent) sentCnt++;
      if (overflow) ovfCnt++;
      if (txStart && !prevStart) begin
        txInBad = 1'b0;
        chk("startIdle", 32'(uBusy), 0);
        if (expQ.size() == 0) begin
          chk("startUnexpected", 32'(txStart), 0);
        end else begin
          chk("startCount", 32'(count), 32'(expQ.size() - 1));
          chk("startByte", 32'(txIn), 32'(expQ[0]));
        end
      end
      prevStart = txStart;
      if (uBusy && !ignoreFrame && txIn !== uShift) txInBad = 1'b1;
      if (uDone) begin
        if (ignoreFrame) begin
          ignoreFrame = 1'b0;
        end else if (expQ.size() == 0) begin
          chk("rxUnexpected", 32'(uDone), 0);
        end else begin
          chk("rxByte", 32'(uShift), 32'(expQ.pop_front()));
          chk("txInStable", 32'(txInBad), 0);
          rxCnt++;
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int r0;
    int o0;
    int n;
    fork
      monitor();
    join_none

    // reset with enable high: txEn must still read 0
    reset  = 1'b1;
    enable = 1'b1;
    repeat (3) tick();
    checkReset("rst");
    reset = 1'b0;
    tick();

    // single byte
    s0 = sentCnt;
    wr(8'h8A, 1'b1);
    waitDrain("t1Drain");
    chk("t1Sent", 32'(sentCnt - s0), 1);
    chk("t1Empty", 32'(empty), 1);

    // burst queued while disabled, then released
    enable = 1'b0;
    tick();
    wr(8'h8A, 1'b1);
    chk("t2Count1", 32'(count), 1);
    wr(8'h7A, 1'b1);
    chk("t2Count2", 32'(count), 2);
    wr(8'h55, 1'b1);
    chk("t2Count3", 32'(count), 3);
    r0 = rxCnt;
    enable = 1'b1;
    waitDrain("t2Drain");
    chk("t2Rx", 32'(rxCnt - r0), 3);

    // fill and overflow
    enable = 1'b0;
    tick();
    for (int i = 0; i < DEPTH; i++) wr(8'h10 + 8'(i), 1'b1);
    chk("t3Full", 32'(full), 1);
    chk("t3CountFull", 32'(count), DEPTH);
    o0 = ovfCnt;
    wr(8'hEE, 1'b0);
    chk("t3Overflow", 32'(overflow), 1);
    chk("t3CountHeld", 32'(count), DEPTH);
    tick();
    chk("t3OverflowPulse", 32'(overflow), 0);
    r0 = rxCnt;
    enable = 1'b1;
    waitDrain("t3Drain");
    chk("t3OvfCount", 32'(ovfCnt - o0), 1);
    chk("t3Rx", 32'(rxCnt - r0), DEPTH);
    chk("t3Empty", 32'(empty), 1);

    // write on the same clock as the pop
    enable = 1'b0;
    tick();
    wr(8'h11, 1'b1);
    wr(8'h22, 1'b1);
    wr(8'h33, 1'b1);
    enable = 1'b1;
    wr(8'h44, 1'b1);
    chk("t4Count", 32'(count), 3);
    chk("t4Start", 32'(txStart), 1);
    r0 = rxCnt;
    waitDrain("t4Drain");
    chk("t4Rx", 32'(rxCnt - r0), 4);

    // enable dropped mid-frame
    s0 = sentCnt;
    wr(8'hA1, 1'b1);
    wr(8'hA2, 1'b1);
    waitBusy("t5Busy");
    enable = 1'b0;
    n = 0;
    while (sentCnt == s0 && n < 500) begin
      tick();
      n++;
    end
    repeat (100) tick();
    chk("t5Sent1", 32'(sentCnt - s0), 1);
    chk("t5Count", 32'(count), 1);
    chk("t5NoStart", 32'(txStart), 0);
    enable = 1'b1;
    waitDrain("t5Drain");
    chk("t5Sent2", 32'(sentCnt - s0), 2);

    // reset mid-frame with bytes queued
    enable = 1'b0;
    tick();
    wr(8'hB1, 1'b1);
    wr(8'hB2, 1'b1);
    wr(8'hB3, 1'b1);
    enable = 1'b1;
    waitBusy("t6Busy");
    chk("t6Queued", 32'(count), 2);
    ignoreFrame = 1'b1;
    expQ.delete();
    reset = 1'b1;
    tick();
    checkReset("t6Rst");
    reset = 1'b0;
    wr(8'hC3, 1'b1);
    repeat (3) tick();
    if (uBusy) chk("t6NoStartBusy", 32'(txStart), 0);
    waitDrain("t6Drain");
    chk("t6Empty", 32'(empty), 1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
